// File: rtl/booth_seq_divider_if.sv
// Handshake and data bundle for booth_seq_divider.
// Signals:
//   start             - operation request, sampled only while the divider is idle
//   dividend, divisor - signed operands, captured on an accepted start
//   quotient          - signed quotient, registered
//   remainder         - signed remainder, registered
//   done              - one-cycle completion pulse
//   busy              - high while an operation is in flight
//   div_by_zero       - sticky flag for the last operation
//   overflow          - sticky flag for the last operation (most-negative / -1)
//   power_consumption - energy estimate of the last operation
// Modports: master drives the request side, slave is the divider.
interface booth_seq_divider_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;
  logic             overflow;
  logic [7:0]       power_consumption;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done, busy, div_by_zero, overflow, power_consumption
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done, busy, div_by_zero, overflow, power_consumption
  );
endinterface

// File: rtl/booth_seq_divider.sv
// Sequential signed restoring divider, one iteration per clock, truncating (round-toward-zero)
// quotient and remainder. Keeps a per-iteration energy estimate: +2 for a kept subtraction,
// +1 for a restore, saturating at 8'hFF.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - booth_seq_divider_if.slave (start/operands in, results/flags/done/busy out)
// Build option: define ZERO_DIVIDEND_SKIP_EN to finish a zero-dividend operation in one cycle
// instead of running all WIDTH iterations (divide-by-zero still takes priority).
module booth_seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                reset,
  booth_seq_divider_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCompute, StDone, StDz} state_e;

  state_e r_state;
  state_e w_state_next;

  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_q;        // dividend magnitude, quotient bits shift in at the bottom
  logic [WIDTH-1:0] r_rem;      // partial remainder magnitude
  logic [WIDTH-1:0] r_dvs_mag;
  logic [CntW-1:0]  r_count;
  logic [7:0]       r_estimate;

  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_done;
  logic             r_dz;
  logic             r_ovf;
  logic [7:0]       r_power;

  logic             w_accept;
  logic [WIDTH-1:0] w_dividend_mag;
  logic [WIDTH-1:0] w_divisor_mag;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH+1:0] w_trial;
  logic             w_trial_ok;
  logic [WIDTH-1:0] w_rem_next;
  logic [8:0]       w_est_sum;
  logic [7:0]       w_est_next;
  logic             w_last;
  logic             w_neg_q;
  logic [WIDTH-1:0] w_q_fixed;
  logic [WIDTH-1:0] w_rem_fixed;
  logic             w_ovf;

  // Unsigned WIDTH-bit magnitudes: |-2^(W-1)| = 2^(W-1) still fits.
  assign w_dividend_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign w_divisor_mag  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

  assign w_accept = (r_state == StIdle) && bus.start;

  // Restoring step. The remainder is always below |divisor| <= 2^(W-1), so the shifted value
  // fits in W+1 bits and one extra bit holds the sign of the trial subtraction.
  assign w_shifted  = {r_rem, r_q[WIDTH-1]};
  assign w_trial    = {1'b0, w_shifted} - {2'b00, r_dvs_mag};
  assign w_trial_ok = ~w_trial[WIDTH+1];
  assign w_rem_next = w_trial_ok ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

  assign w_est_sum  = {1'b0, r_estimate} + (w_trial_ok ? 9'd2 : 9'd1);
  assign w_est_next = w_est_sum[8] ? 8'hFF : w_est_sum[7:0];

  assign w_last = (r_count == CntW'(WIDTH - 1));

  // Most-negative / -1 needs no special datapath: the magnitude quotient 2^(W-1) is not negated
  // and already reads back as -2^(W-1); only the flag is derived here.
  assign w_neg_q     = r_dividend[WIDTH-1] ^ r_divisor[WIDTH-1];
  assign w_q_fixed   = w_neg_q ? -r_q : r_q;
  assign w_rem_fixed = r_dividend[WIDTH-1] ? -r_rem : r_rem;
  assign w_ovf       = (r_dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (r_divisor == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (bus.divisor == '0) begin
            w_state_next = StDz;
`ifdef ZERO_DIVIDEND_SKIP_EN
          end else if (bus.dividend == '0) begin
            w_state_next = StDone;
`endif
          end else begin
            w_state_next = StCompute;
          end
        end
      end
      StCompute: if (w_last) w_state_next = StDone;
      StDone:    w_state_next = StIdle;
      StDz:      w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_dvs_mag   <= '0;
      r_count     <= '0;
      r_estimate  <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
      r_power     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_dividend <= bus.dividend;
            r_divisor  <= bus.divisor;
            r_q        <= w_dividend_mag;
            r_dvs_mag  <= w_divisor_mag;
            r_rem      <= '0;
            r_count    <= '0;
            r_estimate <= '0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
          end
        end
        StCompute: begin
          r_rem      <= w_rem_next;
          r_q        <= {r_q[WIDTH-2:0], w_trial_ok};
          r_estimate <= w_est_next;
          r_count    <= r_count + 1'b1;
        end
        StDone: begin
          r_quotient  <= w_q_fixed;
          r_remainder <= w_rem_fixed;
          r_power     <= r_estimate;
          r_ovf       <= w_ovf;
          r_done      <= 1'b1;
        end
        StDz: begin
          r_quotient  <= '1;
          r_remainder <= r_dividend;
          r_power     <= '0;
          r_dz        <= 1'b1;
          r_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient          = r_quotient;
  assign bus.remainder         = r_remainder;
  assign bus.done              = r_done;
  assign bus.busy              = (r_state != StIdle);
  assign bus.div_by_zero       = r_dz;
  assign bus.overflow          = r_ovf;
  assign bus.power_consumption = r_power;

endmodule

// File: tb/tb_booth_seq_divider.sv
module tb_booth_seq_divider;

  localparam int unsigned W = 8;

  typedef struct {
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic [7:0]        q;
    logic [7:0]        r;
    logic [7:0]        p;
    bit                dz;
    bit                ov;
    int                lat;
  } vec_t;

  logic clk;
  logic reset;

  booth_seq_divider_if #(.WIDTH(W)) bus ();

  booth_seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t sb[$];
  vec_t tbl[$];

`ifdef ZERO_DIVIDEND_SKIP_EN
  localparam bit Skip = 1'b1;
`else
  localparam bit Skip = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: integer division on magnitudes, then sign rules.
  function automatic vec_t model(input logic signed [7:0] a, input logic signed [7:0] b);
    vec_t v;
    int   ia, ib, ma, mb, uq, ur, sq, sr;
    logic [7:0] uq8;
    ia = int'(a);
    ib = int'(b);
    v.a = a;
    v.b = b;
    v.dz = 1'b0;
    v.ov = 1'b0;
    if (ib == 0) begin
      v.q = 8'hFF; v.r = a; v.p = 8'd0; v.dz = 1'b1; v.lat = 1;
    end else if (Skip && ia == 0) begin
      v.q = 8'd0; v.r = 8'd0; v.p = 8'd0; v.lat = 1;
    end else begin
      ma = (ia < 0) ? -ia : ia;
      mb = (ib < 0) ? -ib : ib;
      uq = ma / mb;
      ur = ma % mb;
      uq8 = uq[7:0];
      sq = ((ia < 0) != (ib < 0)) ? -uq : uq;
      sr = (ia < 0) ? -ur : ur;
      v.q = sq[7:0];
      v.r = sr[7:0];
      v.p = 8'(8 + $countones(uq8));
      v.ov = (ia == -128) && (ib == -1);
      v.lat = 9;
    end
    return v;
  endfunction

  function automatic vec_t mk(input logic signed [7:0] a, input logic signed [7:0] b,
                              input logic [7:0] q, input logic [7:0] r, input logic [7:0] p,
                              input bit dz, input bit ov, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.r = r; v.p = p; v.dz = dz; v.ov = ov; v.lat = lat;
    return v;
  endfunction

  // Drive one operation, push its expectation, then wait (bounded) for done and score it.
  task automatic run_op(input vec_t v, input bit hold_start);
    vec_t e;
    int   edges;
    bit   got;
    bit   busy_err;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = v.a;
    bus.divisor  = v.b;
    sb.push_back(v);
    @(posedge clk); #1;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    if (hold_start) begin
      bus.dividend = 8'sd100;
      bus.divisor  = 8'sd7;
    end else begin
      bus.start = 1'b0;
    end
    edges    = 0;
    got      = 1'b0;
    busy_err = 1'b0;
    while (!got && edges < 30) begin
      @(posedge clk); #1;
      edges++;
      if (bus.done) got = 1'b1;
      else if (!bus.busy) busy_err = 1'b1;
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("latency",   edges, e.lat);
      check("quotient",  {24'd0, bus.quotient}, {24'd0, e.q});
      check("remainder", {24'd0, bus.remainder}, {24'd0, e.r});
      check("power",     {24'd0, bus.power_consumption}, {24'd0, e.p});
      check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dz});
      check("overflow",  {31'd0, bus.overflow}, {31'd0, e.ov});
      check("busy_in_done_cycle", {31'd0, bus.busy}, 32'd0);
      check("busy_during_op", {31'd0, busy_err}, 32'd0);
      @(posedge clk); #1;
      check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    end
  endtask

  function automatic logic [31:0] outs_packed();
    return {4'd0, bus.quotient, bus.remainder, bus.done, bus.busy, bus.div_by_zero,
            bus.overflow, bus.power_consumption};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;

    tbl.push_back(mk( 8'sd100,   8'sd7,  8'h0E, 8'h02, 8'd11, 1'b0, 1'b0, 9));
    tbl.push_back(mk(-8'sd100,   8'sd7,  8'hF2, 8'hFE, 8'd11, 1'b0, 1'b0, 9));
    tbl.push_back(mk( 8'sd100,  -8'sd7,  8'hF2, 8'h02, 8'd11, 1'b0, 1'b0, 9));
    tbl.push_back(mk(-8'sd128,  -8'sd1,  8'h80, 8'h00, 8'd9,  1'b0, 1'b1, 9));
    tbl.push_back(mk( 8'sd6,     8'sd3,  8'h02, 8'h00, 8'd9,  1'b0, 1'b0, 9));
    tbl.push_back(mk( 8'sd5,     8'sd0,  8'hFF, 8'h05, 8'd0,  1'b1, 1'b0, 1));
    tbl.push_back(mk(-8'sd7,     8'sd2,  8'hFD, 8'hFF, 8'd10, 1'b0, 1'b0, 9));
    tbl.push_back(mk( 8'sd127,   8'sd1,  8'h7F, 8'h00, 8'd15, 1'b0, 1'b0, 9));
    tbl.push_back(mk(-8'sd128,   8'sd7,  8'hEE, 8'hFE, 8'd10, 1'b0, 1'b0, 9));
    tbl.push_back(mk(-8'sd5,     8'sd0,  8'hFF, 8'hFB, 8'd0,  1'b1, 1'b0, 1));
    if (Skip) tbl.push_back(mk(8'sd0, 8'sd9, 8'h00, 8'h00, 8'd0, 1'b0, 1'b0, 1));
    else      tbl.push_back(mk(8'sd0, 8'sd9, 8'h00, 8'h00, 8'd8, 1'b0, 1'b0, 9));

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_outputs", outs_packed(), 32'd0);

    foreach (tbl[i]) run_op(tbl[i], 1'b0);

    for (int i = 0; i < 16; i++) begin
      logic signed [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(model(ra, rb), 1'b0);
    end

    // Abort 50/3 with a reset during its 4th COMPUTE cycle.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'sd50;
    bus.divisor  = 8'sd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_reset_outputs", outs_packed(), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    check("abort_no_done", {31'd0, seen_done}, 32'd0);

    // 3/-2 with start held and operands changed mid-run: one done, original operands.
    run_op(mk(8'sd3, -8'sd2, 8'hFF, 8'h01, 8'd9, 1'b0, 1'b0, 9), 1'b1);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    check("held_start_single_done", {31'd0, seen_done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
